// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared state encoding and BCD limits for the game timer.
package game_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, SATURATED} timer_state_t;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int TIMER_MAX = 999;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one registered 0..9 BCD digit with increment, clear and carry-out.
module bcd_digit
    import game_timer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);
    logic [3:0] digit_q, digit_d;
    always_comb digit_d = clr ? 4'd0 : !inc ? digit_q : (digit_q == BCD_MAX_DIGIT) ? 4'd0 : digit_q + 4'd1;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) digit_q <= 4'd0;
        else          digit_q <= digit_d;
    assign digit = digit_q;
    assign carry = inc & (digit_q == BCD_MAX_DIGIT);
endmodule

// File: rtl/game_timer_bcd.sv
// game_timer_bcd: counts game seconds from newclk rising edges as three BCD digits.
// Define GAME_TIMER_ROLLOVER_EN to wrap 999->000 with a sticky maxed flag instead of saturating.
module game_timer_bcd
    import game_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int PRESC_W       = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       newclk,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       running,
    output logic       maxed
);
    timer_state_t       state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               newclk_q, running_q, maxed_q, maxed_d;
    logic               rise, cnt_en, tick, c_ones, c_tens, wrap, sat;

    assign rise   = newclk & ~newclk_q;
    assign cnt_en = rise & (state_q == RUNNING) & ~clear;
    assign tick   = cnt_en & (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

    bcd_digit u_ones (.clock(clock), .reset_n(reset_n), .inc(tick),   .clr(clear), .digit(ones),     .carry(c_ones));
    bcd_digit u_tens (.clock(clock), .reset_n(reset_n), .inc(c_ones), .clr(clear), .digit(tens),     .carry(c_tens));
    bcd_digit u_hund (.clock(clock), .reset_n(reset_n), .inc(c_tens), .clr(clear), .digit(hundreds), .carry(wrap));

`ifdef GAME_TIMER_ROLLOVER_EN
    assign sat     = 1'b0;
    assign maxed_d = clear ? 1'b0 : maxed_q | wrap;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
    // The increment that lands on 999 also moves the FSM, so maxed rises with the count.
    assign sat     = tick & (hundreds == BCD_MAX_DIGIT) & (tens == BCD_MAX_DIGIT) & (ones == BCD_MAX_DIGIT - 4'd1);
    assign maxed_d = (state_d == SATURATED);
`endif

    always_comb begin
        state_d = state_q;
        if (clear)      state_d = IDLE;
        else if (sat)   state_d = SATURATED;
        else if (stop)  state_d = (state_q == RUNNING) ? PAUSED : state_q;
        else if (start && (state_q == IDLE || state_q == PAUSED)) state_d = RUNNING;
        presc_d = clear ? '0 : !cnt_en ? presc_q : tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            newclk_q  <= 1'b0;
            running_q <= 1'b0;
            maxed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            newclk_q  <= newclk;
            running_q <= (state_d == RUNNING);
            maxed_q   <= maxed_d;
        end
    end

    assign running = running_q;
    assign maxed   = maxed_q;
endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
- Elapsed-time counter for the minesweeper game, directly downstream of the clock divider.
- Consumes the divider's slow `newclk` square wave in the system `clock` domain, detects its rising edges and counts game seconds.
- Outputs three BCD digits to the seven-segment / VGA score display.
- Game FSM drives start (first reveal), stop (win/loss) and clear (new game).

Parameters:
- TICKS_PER_SEC, default 1: number of `newclk` rising edges per one-second increment; legal range 1..255.
- PRESC_W, default 8: prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- newclk  input  1  divided clock from the divider; sampled as data, never used as a clock.
- start  input  1  one-cycle pulse: begin or resume counting.
- stop  input  1  one-cycle pulse: freeze count.
- clear  input  1  one-cycle pulse: zero count and return to IDLE.
- ones  output  4  BCD seconds units.
- tens  output  4  BCD seconds tens.
- hundreds  output  4  BCD seconds hundreds.
- running  output  1  high while state is RUNNING.
- maxed  output  1  high while state is SATURATED.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - ones/tens/hundreds = 0.
  - prescaler = 0.
  - newclk_q = 0.
  - running = 0, maxed = 0.
- Edge detect:
  - newclk_q <= newclk every cycle.
  - edge = newclk & ~newclk_q, combinational.
  - One edge per `newclk` low-to-high transition.
- States: IDLE, RUNNING, PAUSED, SATURATED. All outputs are registered.
- Control priority per cycle: clear > stop > start.
  - clear, any state: count = 0, prescaler = 0, next state IDLE.
  - stop in RUNNING -> PAUSED. In any other state, stop is a no-op.
  - start in IDLE or PAUSED -> RUNNING. start in RUNNING or SATURATED is ignored.
  - start and stop in the same cycle: stop wins, so RUNNING -> PAUSED and IDLE stays IDLE.
- Counting: qualified by the current state only.
  - An edge in a cycle whose current state is RUNNING is counted, even if stop is asserted that cycle.
  - An edge coinciding with start from IDLE/PAUSED is not counted.
  - An edge coinciding with clear is discarded.
- Prescaler:
  - On a counted edge: if prescaler == TICKS_PER_SEC-1, prescaler <= 0 and count increments; otherwise prescaler++.
  - Holds its value in PAUSED; PAUSED -> RUNNING resumes mid-second.
- BCD increment, visible on the same clock edge that registers the counted edge (latency 1 cycle from newclk rising):
  - ones 9 -> 0 carries into tens.
  - tens 9 -> 0 carries into hundreds.
  - Digits never hold values above 9.
- Saturation:
  - An increment that produces 999 moves to SATURATED the same cycle; maxed = 1 and running = 0.
  - Further edges have no effect; only clear or reset leaves SATURATED.
- Reset asserted mid-count: immediate return to reset values, regardless of clock.

Optional Feature:
- Macro GAME_TIMER_ROLLOVER_EN.
- Defined:
  - No SATURATED state; 999 + 1 wraps to 000 and counting continues in RUNNING.
  - maxed becomes a sticky flag, set on the first wrap and cleared only by clear or reset.
- Undefined: saturating behaviour as specified above; maxed mirrors the SATURATED state.

Decomposition:
- Package game_timer_pkg:
  - timer_state_t enum {IDLE, RUNNING, PAUSED, SATURATED}.
  - BCD_MAX_DIGIT = 4'd9.
  - TIMER_MAX = 999.
- Sub-module bcd_digit: one 4-bit BCD digit.
  - Inputs: inc, clr.
  - Outputs: carry = inc & (digit == 9).
  - Instantiated three times and chained through carry.
- Top level holds the edge detector, prescaler and FSM.

Test Plan:
1. Reset, then start; drive 12 newclk periods (TICKS_PER_SEC=1) -> hundreds/tens/ones = 0/1/2, running = 1. Each digit change occurs exactly 1 clock after the newclk rise.
2. TICKS_PER_SEC=4: start, 6 edges, stop, 5 edges, start, 2 edges -> count = 2. The 5 edges while PAUSED leave count and prescaler unchanged.
3. Preload to 998 via 998 edges, then 3 more edges -> after the first, count = 999, maxed = 1, running = 0; it stays 999. Under GAME_TIMER_ROLLOVER_EN: 999 -> 000 -> 001, maxed sticky at 1.
4. start and stop in the same cycle from RUNNING -> PAUSED. clear and start together -> IDLE with count 0.
5. Edge coinciding with stop in RUNNING -> counted (count +1), then PAUSED. Edge coinciding with start from IDLE -> not counted.
6. Assert reset_n low between clock edges at count 057 -> all outputs zero immediately, before the next clock edge. After release, start resumes from 000.
